// File: rtl/bt_pipe_adder.sv
// Pipelined balanced-ternary adder/subtractor: NTRITS trits rippled across
// STAGES register stages, valid/ready handshake on both sides.
module bt_pipe_adder #(
  parameter int NTRITS = 8,
  parameter int STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*NTRITS-1:0] a,
  input  logic [2*NTRITS-1:0] b,
  input  logic [1:0]          cin,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*NTRITS-1:0] sum,
  output logic [1:0]          cout,
  output logic                enc_err
);

  localparam int K = NTRITS / STAGES;
  localparam int W = 2 * NTRITS;

  function automatic logic [1:0] trit_clean(input logic [1:0] t);
    return (t == 2'b11) ? 2'b00 : t;
  endfunction

  // Trit value as 3-bit two's complement so three of them add without overflow.
  function automatic logic [2:0] trit_val(input logic [1:0] t);
    case (t)
      2'b01:   return 3'b001;
      2'b10:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // Returns {carry, sum} with x + y + c = 3*carry + sum.
  function automatic logic [3:0] trit_add(input logic [1:0] x, input logic [1:0] y,
                                          input logic [1:0] c);
    logic [2:0] s;
    s = trit_val(x) + trit_val(y) + trit_val(c);
    case (s)
      3'b011:  return {2'b01, 2'b00};  // +3
      3'b010:  return {2'b01, 2'b10};  // +2
      3'b001:  return {2'b00, 2'b01};  // +1
      3'b111:  return {2'b00, 2'b10};  // -1
      3'b110:  return {2'b10, 2'b01};  // -2
      3'b101:  return {2'b10, 2'b00};  // -3
      default: return 4'b0000;
    endcase
  endfunction

  logic [W-1:0] a_dec, b_dec;
  logic [1:0]   cin_dec, bt;
  logic         err_in;

  always_comb begin
    a_dec  = '0;
    b_dec  = '0;
    bt     = '0;
    err_in = 1'b0;
    for (int t = 0; t < NTRITS; t++) begin
      a_dec[2*t +: 2] = trit_clean(a[2*t +: 2]);
      bt              = trit_clean(b[2*t +: 2]);
      b_dec[2*t +: 2] = sub ? {bt[0], bt[1]} : bt;
      err_in          = err_in | (a[2*t +: 2] == 2'b11) | (b[2*t +: 2] == 2'b11);
    end
    cin_dec = trit_clean(cin);
    err_in  = err_in | (cin == 2'b11);
  end

  logic [W-1:0]      res_q   [STAGES];
  logic [W-1:0]      x_q     [STAGES];
  logic [W-1:0]      y_q     [STAGES];
  logic [1:0]        carry_q [STAGES];
  logic [STAGES-1:0] err_vec, valid_vec, adv_vec;
  logic              down_free;

  // A stage advances when its result leaves: downstream free or itself advancing.
  always_comb begin
    adv_vec   = '0;
    down_free = out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      adv_vec[s] = valid_vec[s] & down_free;
      down_free  = ~valid_vec[s] | adv_vec[s];
    end
  end

  assign in_ready = ~valid_vec[0] | adv_vec[0];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stg
      logic [W-1:0] x_in, y_in, r_in, r_next;
      logic [1:0]   c_in, c_next;
      logic [3:0]   ta;
      logic         e_in, load;
      logic [W-1:0] res_reg, x_reg, y_reg;
      logic [1:0]   carry_reg;
      logic         err_reg, valid_reg;

      if (gi == 0) begin : src
        assign x_in = a_dec;
        assign y_in = b_dec;
        assign r_in = '0;
        assign c_in = cin_dec;
        assign e_in = err_in;
        assign load = in_valid & in_ready;
      end else begin : src
        assign x_in = x_q[gi-1];
        assign y_in = y_q[gi-1];
        assign r_in = res_q[gi-1];
        assign c_in = carry_q[gi-1];
        assign e_in = err_vec[gi-1];
        assign load = adv_vec[gi-1];
      end

      always_comb begin
        r_next = r_in;
        c_next = c_in;
        ta     = '0;
        for (int t = gi * K; t < gi * K + K; t++) begin
          ta              = trit_add(x_in[2*t +: 2], y_in[2*t +: 2], c_next);
          r_next[2*t +: 2] = ta[1:0];
          c_next          = ta[3:2];
        end
      end

      always_ff @(posedge clk) begin
        if (rst)
          valid_reg <= 1'b0;
        else if (load)
          valid_reg <= 1'b1;
        else if (adv_vec[gi])
          valid_reg <= 1'b0;
      end

      // Payload needs no reset: it is only observed through valid_reg.
      always_ff @(posedge clk) begin
        if (load) begin
          res_reg   <= r_next;
          x_reg     <= x_in;
          y_reg     <= y_in;
          carry_reg <= c_next;
          err_reg   <= e_in;
        end
      end

      assign res_q[gi]     = res_reg;
      assign x_q[gi]       = x_reg;
      assign y_q[gi]       = y_reg;
      assign carry_q[gi]   = carry_reg;
      assign err_vec[gi]   = err_reg;
      assign valid_vec[gi] = valid_reg;
    end
  endgenerate

  assign out_valid = valid_vec[STAGES-1];
  assign sum       = out_valid ? res_q[STAGES-1]   : '0;
  assign cout      = out_valid ? carry_q[STAGES-1] : 2'b00;
  assign enc_err   = out_valid & err_vec[STAGES-1];

endmodule

// File: doc/bt_pipe_adder.md
Name: bt_pipe_adder

Overview:
- Parametrised, pipelined multi-trit balanced-ternary adder/subtractor; generational successor to the single-trit full adder in the ternary datapath.
- Ripple-carries across NTRITS trits, split into STAGES register stages, with valid/ready handshakes on both sides.
- Feeds the ternary ALU. Carry-out serves as the wide-word overflow trit.

Parameters:
- NTRITS, 8, operand width in trits; must be a multiple of STAGES.
- STAGES, 2, number of pipeline register stages (1..NTRITS); also the latency in cycles.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- a  in  2*NTRITS  operand A; trit i at bits [2i+1:2i], trit 0 least significant
- b  in  2*NTRITS  operand B, same packing
- cin  in  2  carry-in trit
- sub  in  1  1 = compute a - b + cin; 0 = compute a + b + cin
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- sum  out  2*NTRITS  result trits
- cout  out  2  carry-out trit
- enc_err  out  1  an illegal trit code was present in the accepted beat

Behaviour:
- Trit encoding, as in the package trit type:
  - 2'b00 = 0, 2'b01 = +1, 2'b10 = -1.
  - 2'b11 is illegal. Each illegal input trit (a, b or cin) is treated as 0, and enc_err is set for that beat.
- Subtract mode: every b trit is negated before addition (01<->10, 00 unchanged, illegal -> 0). cin is never negated.
- Per-trit arithmetic: s = x + y + c in {-3..+3}, mapped to (sum, carry) with s = 3*carry + sum, sum in {-1, 0, +1}. This must match the single-trit adder's 27-entry table exactly.
- Pipeline partition:
  - K = NTRITS/STAGES.
  - Stage s combinationally resolves trits [s*K, s*K+K-1] using the carry held in the stage-(s-1) register (cin for s = 0).
  - Each stage then registers: resolved low trits, remaining high operand trits (already sub-negated), carry, enc_err, and a valid bit.
- Latency: a beat accepted at edge N appears with out_valid = 1 after edge N+STAGES, when no stall occurs.
  - out_valid, sum, cout and enc_err come directly from the last stage register. No combinational path from inputs to outputs.
- Handshake:
  - Transfer occurs on a cycle when valid and ready are both high.
  - Stage s advances when its downstream stage is empty or advancing. The last stage advances when out_ready = 1.
  - in_ready = !valid[0] || advance[0]. in_ready must not depend combinationally on in_valid.
  - While out_valid = 1 and out_ready = 0, sum, cout and enc_err hold stable. No beat is dropped or duplicated.
  - Full throughput: one beat per cycle when out_ready is held at 1.
- Full pipeline: all STAGES valid bits set and out_ready = 0 -> in_ready = 0. Beats offered in this state are not accepted.
- Simultaneous events: when the last stage drains and a new input is accepted in the same cycle, the whole pipeline shifts. Occupancy stays at STAGES.
- Reset (synchronous, active-high, highest priority):
  - All valid bits clear; out_valid = 0, sum = 0, cout = 0, enc_err = 0.
  - in_ready = 1 from the first cycle after reset deasserts.
  - Reset mid-operation discards all in-flight beats. No partial result ever appears at the output.
- Data registers other than valid bits may skip reset, but outputs must read 0 whenever out_valid = 0 after reset.
- Edge case STAGES = 1: the whole word is resolved in one combinational ripple. Latency 1.

Test Plan:
- NTRITS=4, STAGES=2, sub=0. a = +40 (all +1), b = +1, cin = 0 -> sum = -40 (all -1), cout = +1 (81 - 40 = 41), out_valid exactly 2 cycles after accept.
- sub=1, a = +5, b = +7, cin = 0 -> sum = -2 (trits 0,0,-1,+1 MSB-first), cout = 0. Then a = -40, b = +1, sub=1 -> sum = +40, cout = -1.
- Exhaustive single-trit check, NTRITS=1, STAGES=1: all 27 (a, b, cin) combinations match the single-trit table. Plus 1000 random NTRITS=8 beats checked as integer value a ± b + cin = 3^8*cout + sum.
- Backpressure: stream 6 beats with out_ready low for cycles 3..6. in_ready falls when 2 beats are buffered; outputs are held stable; all 6 results arrive in order with no loss or duplication.
- Illegal code: a trit 0 = 2'b11, rest zero, b = +1 -> sum = +1, enc_err = 1 on that beat only.
- Reset mid-operation: assert rst with 2 beats in flight -> out_valid = 0 next cycle and neither result ever appears. A beat accepted after reset completes normally.
